// File: rtl/uart_bus_sequencer.sv
// Serial debug port command sequencer: turns 34-bit command words into single
// register-bus reads/writes with an ack timeout and returns a 34-bit response.
module uart_bus_sequencer #(
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          AUTOINC_RST = 1'b1
) (
  input  logic        i_clk,
  input  logic        rst,
  input  logic        i_cmd_stb,
  input  logic [33:0] i_cmd_word,
  output logic        o_cmd_busy,
  output logic        o_bus_cyc,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata,
  output logic        o_rsp_stb,
  output logic [33:0] o_rsp_word,
  input  logic        i_rsp_busy,
  output logic [1:0]  o_dbg_state
);

  // Response handshake: o_rsp_stb is valid, i_rsp_busy is the inverse of ready;
  // a response transfers on any rising edge where o_rsp_stb=1 and i_rsp_busy=0,
  // and o_rsp_word stays constant until then.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [1:0]  OP_R     = 2'b00;
  localparam logic [1:0]  OP_W     = 2'b01;
  localparam logic [1:0]  OP_A     = 2'b10;
  localparam logic [1:0]  OP_S     = 2'b11;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [33:0] RSP_FAIL = {2'b11, 32'hFFFF_FFFF};

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        autoinc_q, autoinc_d;
  logic        ovf_q, ovf_d;
  logic [15:0] tmo_q, tmo_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [33:0] rsp_q, rsp_d;

  logic [1:0]  cmd_op;
  logic [31:0] cmd_pl;

  assign cmd_op = i_cmd_word[33:32];
  assign cmd_pl = i_cmd_word[31:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    autoinc_d = autoinc_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rsp_d     = rsp_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          case (cmd_op)
            OP_A: begin
              addr_d  = cmd_pl;
              rsp_d   = {OP_A, cmd_pl};
              state_d = ST_RSP;
            end
            OP_S: begin
              autoinc_d = cmd_pl[0];
              if (cmd_pl[1]) ovf_d = 1'b0;
              // Report the flag as it was before this command cleared it.
              rsp_d   = {OP_S, 30'b0, ovf_q, cmd_pl[0]};
              state_d = ST_RSP;
            end
            OP_W: begin
              we_d    = 1'b1;
              wdata_d = cmd_pl;
              tmo_d   = '0;
              state_d = ST_BUS;
            end
            default: begin
              we_d    = 1'b0;
              tmo_d   = '0;
              state_d = ST_BUS;
            end
          endcase
        end
      end
      ST_BUS: begin
        if (i_cmd_stb) ovf_d = 1'b1;
        // Error takes priority over a simultaneous ack; an ack in the final
        // timeout cycle is still honoured because it is checked first.
        if (i_bus_err) begin
          rsp_d   = RSP_FAIL;
          state_d = ST_RSP;
        end else if (i_bus_ack) begin
          rsp_d   = we_q ? {OP_W, addr_q} : {OP_R, i_bus_rdata};
          if (autoinc_q) addr_d = addr_q + 32'd1;
          state_d = ST_RSP;
        end else if (tmo_q == TMO_LAST) begin
          rsp_d   = RSP_FAIL;
          state_d = ST_RSP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_RSP: begin
        if (i_cmd_stb) ovf_d = 1'b1;
        if (!i_rsp_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      autoinc_q <= AUTOINC_RST;
      ovf_q     <= 1'b0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      autoinc_q <= autoinc_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rsp_q     <= rsp_d;
    end
  end

  // Bus fields come straight from registers, so they cannot move mid-cycle.
  assign o_cmd_busy  = (state_q != ST_IDLE);
  assign o_bus_cyc   = (state_q == ST_BUS);
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_wdata = wdata_q;
  assign o_rsp_stb   = (state_q == ST_RSP);
  assign o_rsp_word  = rsp_q;
  assign o_dbg_state = state_q;

endmodule
